// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined segmented adder/subtractor with valid/ready handshake
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid, in_ready   input beat handshake; a, b, cin, sub captured on acceptance
//   a, b     [WIDTH]     operands
//   cin                  carry-in (add) / borrow-in (sub)
//   sub                  0 = add, 1 = subtract
//   out_valid, out_ready result handshake
//   sum      [WIDTH]     result
//   cout                 carry-out (add) / no-borrow flag (sub)
//   ovf                  signed two's-complement overflow
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SDIV = (STAGES > 0) ? STAGES : 1;
    localparam int SEG  = WIDTH / SDIV;

    if (STAGES < 1 || WIDTH % SDIV != 0) begin : g_bad_params
        $error("pipe_addsub: STAGES must be >= 1 and divide WIDTH");
    end

    logic w_adv;
    logic r_ovf;

    // Whole pipeline moves in lockstep; it only freezes when a result is stuck at the output.
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Stage k adds slice k. It receives the not-yet-added upper operand slices
    // (IW bits) and the already-finished lower result slices from stage k-1.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int IW = WIDTH - k * SEG;
        logic [IW-1:0]          w_a;
        logic [IW-1:0]          w_b;
        logic                   w_c;
        logic                   w_v;
        logic [SEG:0]           w_add;
        logic [(k+1)*SEG-1:0]   w_s;
        logic [(k+1)*SEG-1:0]   r_s;
        logic                   r_c;
        logic                   r_v;

        if (k == 0) begin : g_in
            // Subtraction is a + ~b + ~cin, so a borrow-in becomes a missing carry-in.
            assign w_a = a;
            assign w_b = sub ? ~b : b;
            assign w_c = sub ? ~cin : cin;
            assign w_v = in_valid;
            assign w_s = w_add[SEG-1:0];
        end else begin : g_in
            assign w_a = g_st[k-1].g_fw.r_a;
            assign w_b = g_st[k-1].g_fw.r_b;
            assign w_c = g_st[k-1].r_c;
            assign w_v = g_st[k-1].r_v;
            assign w_s = {w_add[SEG-1:0], g_st[k-1].r_s};
        end

        assign w_add = {1'b0, w_a[SEG-1:0]} + {1'b0, w_b[SEG-1:0]} + {{SEG{1'b0}}, w_c};

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_v <= 1'b0;
            else if (w_adv)
                r_v <= w_v;
        end

        if (k < STAGES - 1) begin : g_fw
            logic [IW-SEG-1:0] r_a;
            logic [IW-SEG-1:0] r_b;
            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_a <= w_a[IW-1:SEG];
                    r_b <= w_b[IW-1:SEG];
                    r_s <= w_s;
                    r_c <= w_add[SEG];
                end
            end
        end else begin : g_out
            // Last stage holds the MSB slice, so overflow is resolved here.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s   <= '0;
                    r_c   <= 1'b0;
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_s   <= w_s;
                    r_c   <= w_add[SEG];
                    r_ovf <= (w_a[SEG-1] == w_b[SEG-1]) && (w_add[SEG-1] != w_a[SEG-1]);
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].r_v;
    assign sum       = g_st[STAGES-1].r_s;
    assign cout      = g_st[STAGES-1].r_c;
    assign ovf       = r_ovf;
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: three pipe_addsub configurations checked against an arithmetic reference model
module tb_pipe_addsub;
    typedef struct packed {
        logic [33:0] r;
        int          acc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  iv, ci, si, ordy;
    logic [2:0]  ir, ov, co, of;
    logic [31:0] ai [3];
    logic [31:0] bi [3];
    logic [31:0] sx [3];
    logic [31:0] s0;
    logic [7:0]  s1;
    logic [15:0] s2;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    ent_t        fifo [3][256];
    int          wp [3];
    int          rp [3];
    int          stall_edge [3];
    logic        seen [3];
    logic        held [3];
    logic [33:0] hv [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_addsub #(.WIDTH(32), .STAGES(4)) u0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(ai[0]), .b(bi[0]), .cin(ci[0]), .sub(si[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(s0), .cout(co[0]), .ovf(of[0]));
    pipe_addsub #(.WIDTH(8), .STAGES(1)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(ai[1][7:0]), .b(bi[1][7:0]), .cin(ci[1]), .sub(si[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(s1), .cout(co[1]), .ovf(of[1]));
    pipe_addsub #(.WIDTH(16), .STAGES(8)) u2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(ai[2][15:0]), .b(bi[2][15:0]), .cin(ci[2]), .sub(si[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(s2), .cout(co[2]), .ovf(of[2]));

    always_comb begin
        sx[0] = s0;
        sx[1] = {24'd0, s1};
        sx[2] = {16'd0, s2};
    end

    function automatic int wof(int d);
        return d == 0 ? 32 : d == 1 ? 8 : 16;
    endfunction

    function automatic int sof(int d);
        return d == 0 ? 4 : d == 1 ? 1 : 8;
    endfunction

    function automatic logic [31:0] msk(int d);
        return wof(d) == 32 ? 32'hFFFF_FFFF : (32'd1 << wof(d)) - 32'd1;
    endfunction

    // {ovf, cout, sum} straight from the arithmetic definition.
    function automatic logic [33:0] model(int d, logic [31:0] a, logic [31:0] b, logic c, logic s);
        int          w;
        logic [32:0] be;
        logic [32:0] r;
        logic [31:0] sm;
        w  = wof(d);
        be = {1'b0, (s ? ~b : b) & msk(d)};
        r  = {1'b0, a & msk(d)} + be + {32'd0, s ? ~c : c};
        sm = r[31:0] & msk(d);
        return {(a[w-1] == be[w-1]) && (sm[w-1] != a[w-1]), r[w], sm};
    endfunction

    function automatic logic [33:0] outv(int d);
        return {of[d], co[d], sx[d]};
    endfunction

    task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d got=%h want=%h", nm, d, act, exp);
        end
    endtask

    task automatic set_in(int d, logic v, logic [31:0] a, logic [31:0] b, logic c, logic s);
        iv[d] = v;
        ai[d] = a & msk(d);
        bi[d] = b & msk(d);
        ci[d] = c;
        si[d] = s;
    endtask

    function automatic logic [31:0] rnd();
        return $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom;
    endfunction

    // Scoreboard: accepted beats queue up, results must emerge in order, exactly once.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                rp[d]   = wp[d];
                seen[d] = 1'b0;
                held[d] = 1'b0;
                chk("rst_out", d, {ov[d], outv(d)}, 64'd0);
                chk("rst_ready", d, ir[d], 1);
            end else begin
                chk("in_ready", d, ir[d], !ov[d] || ordy[d]);
                if (held[d])
                    chk("hold", d, {ov[d], outv(d)}, {1'b1, hv[d]});
                if (ov[d]) begin
                    if (wp[d] == rp[d]) begin
                        chk("unexpected_out", d, ov[d], 0);
                    end else begin
                        chk("result", d, outv(d), fifo[d][rp[d] & 255].r);
                        if (!seen[d] && fifo[d][rp[d] & 255].acc > stall_edge[d])
                            chk("latency", d, cyc, fifo[d][rp[d] & 255].acc + sof(d) - 1);
                        seen[d] = 1'b1;
                        if (ordy[d]) begin
                            rp[d]++;
                            seen[d] = 1'b0;
                        end
                    end
                end
                held[d] = ov[d] && !ordy[d];
                hv[d]   = outv(d);
                if (ov[d] && !ordy[d])
                    stall_edge[d] = cyc + 1;
                if (iv[d] && ir[d]) begin
                    fifo[d][wp[d] & 255] = '{r: model(d, ai[d], bi[d], ci[d], si[d]), acc: cyc + 1};
                    wp[d]++;
                end
            end
        end
    end

    task automatic beat1(int d, logic [31:0] a, logic [31:0] b, logic c, logic s, logic [33:0] exp);
        int n = 0;
        @(posedge clk); #1;
        set_in(d, 1'b1, a, b, c, s);
        @(posedge clk); #1;
        iv[d] = 1'b0;
        while (!ov[d] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("dir_latency", d, n, sof(d) - 1);
        chk("dir_result", d, outv(d), exp);
    endtask

    task automatic burst(int d);
        int run = 0;
        int best = 0;
        int tot = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (ov[d]) begin
                run++;
                tot++;
            end else begin
                run = 0;
            end
            if (run > best) best = run;
            set_in(d, i < 8, $urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        chk("burst_run", d, best, 8);
        chk("burst_count", d, tot, 8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            set_in(d, 1'b0, 0, 0, 1'b0, 1'b0);
            ordy[d]       = 1'b1;
            wp[d]         = 0;
            rp[d]         = 0;
            stall_edge[d] = -1;
            seen[d]       = 1'b0;
            held[d]       = 1'b0;
            hv[d]         = '0;
        end
        #1 rst = 1'b1;
        for (int d = 0; d < 3; d++)
            set_in(d, 1'b1, rnd(), rnd(), 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        for (int d = 0; d < 3; d++) iv[d] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) chk("post_rst_idle", d, ov[d], 0);
        end

        chk("model_carry", 0, model(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0), 34'h1_0000_0000);
        chk("model_sub", 0, model(0, 32'h5, 32'h7, 1'b0, 1'b1), 34'h0_FFFF_FFFE);
        chk("model_ovf", 0, model(0, 32'h8000_0000, 32'h1, 1'b0, 1'b1), 34'h3_7FFF_FFFF);
        chk("model_w8", 1, model(1, 32'h7F, 32'h1, 1'b0, 1'b0), 34'h2_0000_0080);

        beat1(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 34'h1_0000_0000);
        beat1(0, 32'h5, 32'h7, 1'b0, 1'b1, 34'h0_FFFF_FFFE);
        beat1(0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 34'h3_7FFF_FFFF);
        beat1(1, 32'hFF, 32'h1, 1'b0, 1'b0, 34'h1_0000_0000);
        beat1(1, 32'h80, 32'h1, 1'b0, 1'b1, 34'h3_0000_007F);
        beat1(2, 32'hFFFF, 32'h1, 1'b0, 1'b0, 34'h1_0000_0000);
        beat1(2, 32'h7FFF, 32'h0, 1'b1, 1'b0, 34'h2_0000_8000);

        for (int d = 0; d < 3; d++) burst(d);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                set_in(d, $urandom_range(0, 3) != 0, rnd(), rnd(), 1'($urandom), 1'($urandom));
                ordy[d] = $urandom_range(0, 2) != 0;
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            iv[d]   = 1'b0;
            ordy[d] = 1'b1;
        end
        repeat (20) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk("drained", d, wp[d] - rp[d], 0);

        for (int i = 0; i < 5; i++) begin
            for (int d = 0; d < 3; d++)
                set_in(d, 1'b1, rnd(), rnd(), 1'($urandom), 1'($urandom));
            @(posedge clk); #1;
        end
        chk("pre_rst_valid", 0, ov[0], 1);
        #2 rst = 1'b1;
        for (int d = 0; d < 3; d++) iv[d] = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("async_rst_drop", d, {ov[d], outv(d)}, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) chk("flushed", d, ov[d], 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
